// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared defaults and tag type for the multiplier arbiter
//
// Purpose: defaults for operand width, requester count and multiplier latency,
// plus the {valid, id} tag that follows each issued operation through the
// external multiplier pipeline.
// Ports: none (package).

package mult_pkg;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 2;
  localparam int ID_W     = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector
//
// Purpose: grants the first eligible requester found by scanning upward from
// ptr, wrapping modulo NREQ.
// Ports:
//   eligible [NREQ]   requesters allowed to issue this cycle
//   ptr      [IW]     index with the highest priority this cycle
//   grant    [NREQ]   one-hot grant, or zero when nothing is eligible

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin front end sharing one external multiplier
//
// Purpose: arbitrates NREQ requesters onto a single pipelined multiplier,
// tracks each issued operation with a tag pipeline, and parks each product in
// a per-requester response register until the requester accepts it.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot or 0)
//   req_a, req_b          packed operands, N bits per requester
//   resp_valid/resp_ready per-requester response handshake
//   resp_data             packed products, 2N bits per requester
//   mul_a, mul_b          operands to the external multiplier (zero when idle)
//   mul_result            registered product from the external multiplier
//   busy                  any operation issued but not yet captured

module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*N-1:0]     req_a,
  input  logic [NREQ*N-1:0]     req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*2*N-1:0]   resp_data,
  output logic [N-1:0]          mul_a,
  output logic [N-1:0]          mul_b,
  input  logic [2*N-1:0]        mul_result,
  output logic                  busy
);

  localparam int IW = ID_W;

  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] pending_n;
  logic [NREQ-1:0] resp_valid_n;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gid;
  logic            hs;
  tag_t            tag [LAT];
  // Tag that has left the last stage: mul_result belongs to its id this cycle.
  tag_t            out_tag;
  logic [2*N-1:0]  data [NREQ];

  // A requester with an operation in flight or an unclaimed result may not
  // issue again; reset masks everything so req_ready stays low.
  assign eligible = req_valid & ~pending & ~resp_valid & {NREQ{~reset}};

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

  assign req_ready = grant;
  assign hs        = |grant;
  assign busy      = |pending;

  always_comb begin
    gid   = '0;
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gid   = IW'(i);
        mul_a = req_a[i*N +: N];
        mul_b = req_b[i*N +: N];
      end
    end
  end

  // Capture and issue never target the same id in one cycle: a pending
  // requester is not eligible, and a captured one has resp_valid low until now.
  always_comb begin
    pending_n    = pending;
    resp_valid_n = resp_valid & ~resp_ready;
    if (hs) begin
      pending_n[gid] = 1'b1;
    end
    if (out_tag.valid) begin
      pending_n[out_tag.id]    = 1'b0;
      resp_valid_n[out_tag.id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      pending    <= '0;
      resp_valid <= '0;
      out_tag    <= '0;
      for (int j = 0; j < LAT; j++) begin
        tag[j] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        data[i] <= '0;
      end
    end else begin
      if (hs) begin
        ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + IW'(1);
      end
      pending    <= pending_n;
      resp_valid <= resp_valid_n;
      tag[0]     <= '{valid: hs, id: gid};
      for (int j = 1; j < LAT; j++) begin
        tag[j] <= tag[j-1];
      end
      out_tag <= tag[LAT-1];
      if (out_tag.valid) begin
        data[out_tag.id] <= mul_result;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_resp
    assign resp_data[i*2*N +: 2*N] = data[i];
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter

module tb_mult_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_a = '0;
  logic [NREQ*N-1:0]   req_b = '0;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready = '0;
  logic [NREQ*2*N-1:0] resp_data;
  logic [N-1:0]        mul_a;
  logic [N-1:0]        mul_b;
  logic [2*N-1:0]      mul_result = '0;
  logic                busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [63:0] val;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  mult_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External multiplier: operands taken at the handshake edge, product
  // registered LAT edges later.
  logic [63:0] p0, p1;
  always @(posedge clk) begin
    p0         <= 64'(mul_a) * 64'(mul_b);
    p1         <= p0;
    mul_result <= p1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    int  k;
    if (!reset) begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      check("ready_implies_valid", 64'(req_ready & ~req_valid), 64'd0);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id  = i;
        e.val = 64'(req_a[i*N +: N]) * 64'(req_b[i*N +: N]);
        sbq.push_back(e);
      end
      if (resp_valid[i] && resp_ready[i]) begin
        k = -1;
        for (int j = sbq.size() - 1; j >= 0; j--) begin
          if (sbq[j].id == i) k = j;
        end
        if (k < 0) begin
          check("sb_unexpected_resp", 64'(i), 64'hFFFF);
        end else begin
          check("sb_resp_data", resp_data[i*2*N +: 2*N], sbq[k].val);
          sbq.delete(k);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; resp_ready = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    repeat (8) @(posedge clk);
    #1;
    resp_ready = '0;
    check("sb_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    vec_t vt[6];
    int   glog[$];
    int   gcnt[NREQ];
    vt[0] = '{0, 32'd3,         32'd5,         64'd15};
    vt[1] = '{0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001};
    vt[2] = '{1, 32'd0,         32'h12345678,  64'd0};
    vt[3] = '{2, 32'h00010000,  32'h00010000,  64'h0000000100000000};
    vt[4] = '{3, 32'hDEADBEEF,  32'd2,         64'h00000001BD5B7DDE};
    vt[5] = '{1, 32'd1,         32'hFFFFFFFF,  64'h00000000FFFFFFFF};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_data", 64'(resp_data[63:0]), 64'd0);
    check("idle_mul_a", 64'(mul_a), 64'd0);

    // Single operations from the table: grant, operands, latency, product.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      req_valid = NREQ'(1 << vt[v].id);
      req_a[vt[v].id*N +: N] = vt[v].a;
      req_b[vt[v].id*N +: N] = vt[v].b;
      @(negedge clk);
      check("tbl_grant", 64'(req_ready), 64'(1 << vt[v].id));
      check("tbl_mul_a", 64'(mul_a), 64'(vt[v].a));
      check("tbl_mul_b", 64'(mul_b), 64'(vt[v].b));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("tbl_busy", 64'(busy), 64'd1);
      check("tbl_mul_a_idle", 64'(mul_a), 64'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("tbl_resp_early", 64'(resp_valid), 64'd0);
      @(posedge clk); #1;
      resp_ready = NREQ'(1 << vt[v].id);
      @(negedge clk);
      check("tbl_resp_valid", 64'(resp_valid), 64'(1 << vt[v].id));
      check("tbl_resp_data", resp_data[vt[v].id*2*N +: 2*N], vt[v].exp);
      check("tbl_busy_done", 64'(busy), 64'd0);
      @(posedge clk); #1;
      resp_ready = '0;
      @(negedge clk);
      check("tbl_resp_cleared", 64'(resp_valid), 64'd0);
    end

    // All four requesters continuously valid from ptr=0.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'(100 + i);
      req_b[i*N +: N] = 32'(7 * i + 1);
    end
    resp_ready = '1;
    req_valid  = '1;
    for (int j = 0; j < NREQ; j++) begin
      @(negedge clk);
      check("rr_grant_seq", 64'(req_ready), 64'(1 << j));
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      @(negedge clk);
      check("rr_resp_seq", 64'(resp_valid), 64'(1 << j));
      @(posedge clk);
    end
    #1;
    drain();

    // Backpressure on requester 1 while 0/2/3 keep being served.
    do_reset();
    req_a[1*N +: N] = 32'h00000ABC;
    req_b[1*N +: N] = 32'h00001000;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    req_valid  = 4'b1111;
    resp_ready = 4'b1101;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_ready1_low", 64'(req_ready[1]), 64'd0);
      check("bp_resp1_held", 64'(resp_valid[1]), 64'd1);
      if (req_ready != '0) begin
        glog.push_back($clog2(req_ready));
        gcnt[$clog2(req_ready)]++;
      end
      @(posedge clk);
    end
    check("bp_data1_held", resp_data[1*2*N +: 2*N], 64'h0000000000ABC000);
    check("bp_first_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd2);
    check("bp_second_grant", 64'(glog.size() > 1 ? glog[1] : -1), 64'd3);
    check("bp_third_grant", 64'(glog.size() > 2 ? glog[2] : -1), 64'd0);
    check("bp_served_0", 64'(gcnt[0] >= 2), 64'd1);
    check("bp_served_2", 64'(gcnt[2] >= 2), 64'd1);
    check("bp_served_3", 64'(gcnt[3] >= 2), 64'd1);
    #1;
    drain();

    // Consume and re-issue from requester 2.
    do_reset();
    req_a[2*N +: N] = 32'd9;
    req_b[2*N +: N] = 32'd11;
    req_valid = 4'b0100;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ci_resp_valid", 64'(resp_valid[2]), 64'd1);
    check("ci_no_grant_waiting", 64'(req_ready[2]), 64'd0);
    @(posedge clk); #1;
    resp_ready = 4'b0100;
    @(negedge clk);
    check("ci_no_grant_consume", 64'(req_ready[2]), 64'd0);
    @(posedge clk); #1;
    resp_ready = '0;
    @(negedge clk);
    check("ci_regrant_next", 64'(req_ready[2]), 64'd1);
    @(posedge clk); #1;
    drain();

    // Reset while operations for 3 and 0 are in flight.
    do_reset();
    req_a[3*N +: N] = 32'd1234;
    req_b[3*N +: N] = 32'd5678;
    req_a[0*N +: N] = 32'd42;
    req_b[0*N +: N] = 32'd43;
    req_valid = 4'b1000;
    @(negedge clk);
    check("mr_grant3", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("mr_grant0", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("mr_ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;
    sbq.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("mr_no_resp", 64'(resp_valid), 64'd0);
      check("mr_busy_low", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("mr_ptr_zero", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters.
REQ-003 SHALL have parameter LAT, default 2, fixed multiplier latency in clock edges from operand capture to registered product.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester grant; one-hot or zero.
REQ-008 SHALL have port req_a  input  NREQ*N  packed operand A; slice i belongs to requester i.
REQ-009 SHALL have port req_b  input  NREQ*N  packed operand B; slice i belongs to requester i.
REQ-010 SHALL have port resp_valid  output  NREQ  per-requester result available.
REQ-011 SHALL have port resp_ready  input  NREQ  per-requester result accept.
REQ-012 SHALL have port resp_data  output  NREQ*2N  packed result; slice i is 2N bits.
REQ-013 SHALL have port mul_a  output  N  operand A to the external pipelined multiplier.
REQ-014 SHALL have port mul_b  output  N  operand B to the external pipelined multiplier.
REQ-015 SHALL have port mul_result  input  2N  registered unsigned product from the multiplier.
REQ-016 SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-017 Eligibility SHALL be eligible[i] = req_valid[i] & ~pending[i] & ~resp_valid[i], using registered pending and resp_valid; at most one operation per requester in flight or awaiting pickup.
REQ-018 Arbitration SHALL be round-robin from pointer ptr: grant the first eligible index scanning ptr, ptr+1, ... modulo NREQ.
REQ-019 req_ready SHALL be combinational, same cycle as req_valid; handshake = req_valid[g] & req_ready[g] at a rising edge.
REQ-020 On grant g, ptr SHALL become (g+1) mod NREQ; with no grant ptr SHALL hold.
REQ-021 mul_a/mul_b SHALL carry req_a/req_b slice g combinationally in the grant cycle, and zero when there is no grant.
REQ-022 A tag pipeline of LAT stages {valid, id} SHALL track issued operations; stage 0 is loaded at the handshake edge.
REQ-023 The tag leaving stage LAT-1 SHALL mark mul_result as belonging to that id. At the next edge, mul_result SHALL be written into resp_data[id], resp_valid[id] SHALL be set and pending[id] cleared.
REQ-024 Timing SHALL be: handshake at edge k -> resp_valid[id] high after edge k+LAT+1 (LAT=2: edge k+3).
REQ-025 pending[g] SHALL be set at the handshake edge and held until result capture.
REQ-026 resp_valid[i] SHALL clear at the edge where resp_valid[i] & resp_ready[i]; resp_data[i] SHALL hold until then.
REQ-027 Re-issue by requester i SHALL NOT occur in the same cycle its response is consumed; the earliest re-grant is the following cycle.
REQ-028 Products SHALL be unsigned, full 2N bits, with no truncation.
REQ-029 busy SHALL equal OR of pending.
REQ-030 Back-to-back grants to different requesters SHALL be permitted every cycle (throughput 1 op/cycle).

Reset
REQ-031 reset SHALL clear ptr to 0 and clear pending, resp_valid, all tag valids and resp_data.
REQ-032 While reset is high, req_ready SHALL be 0.
REQ-033 Reset mid-operation SHALL discard in-flight results; stale mul_result values SHALL never set resp_valid.

Structure
REQ-034 Shared package mult_pkg SHALL hold the N, NREQ and LAT defaults and the tag struct type {valid, id[$clog2(NREQ)-1:0]}.
REQ-035 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: eligible, ptr; output: one-hot grant).
REQ-036 The multiplier SHALL be external; this block contains no arithmetic.

Verification
REQ-037 Single op: req 0 with A=3, B=5, edge k -> resp_valid[0] at edge k+3, resp_data[0]=15, busy low after capture.
REQ-038 Max values: A=B=0xFFFFFFFF -> resp_data=0xFFFFFFFE00000001.
REQ-039 All four requesters valid continuously, ptr=0 -> grants 0,1,2,3 on consecutive cycles; results arrive on 4 consecutive cycles in the same order.
REQ-040 Backpressure: requester 1 holds resp_ready=0 for 10 cycles -> req_ready[1] stays 0, and requesters 0/2/3 are still served round-robin.
REQ-041 Consume/re-issue: resp_ready[2]=1 while req_valid[2]=1 -> no grant to 2 that cycle; grant the next cycle.
REQ-042 Reset one cycle after issuing for requester 3 -> no resp_valid for the following 5 cycles, ptr=0, busy=0.
